risc_sequencer: RTL and testbench

Instruction-cycle controller for the 8-bit accumulator CPU inside `top`. It sits directly downstream of the instruction register and accumulator zero flag. It runs the fixed 8-phase fetch/execute cycle and drives every datapath control strobe: address mux, memory read/write, IR/PC/AC loads, PC increment and the CPU `halt` line. It also counts retired instructions for debug and bench visibility.

---
 rtl/risc_pkg.sv | 46 ++++
 rtl/risc_phase_counter.sv | 32 +++
 rtl/risc_sequencer.sv | 132 +++++++++++++
 tb/tb_risc_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared opcode, phase and strobe definitions for the accumulator CPU sequencer.
package risc_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned PH_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PH_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } strobes_t;

  // Instructions that read an operand and load the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// 3-bit wrapping instruction-phase counter; hold freezes the current phase.
module risc_phase_counter
  import risc_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   hold,
  output phase_e phase
);

  phase_e phase_q;
  phase_e phase_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_q <= PH_INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  // STORE + 1 wraps naturally back to INST_ADDR in 3 bits.
  always_comb begin
    phase_d = phase_q;
    if (!hold) begin
      phase_d = phase_e'(PH_W'(phase_q) + PH_W'(1));
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/risc_sequencer.sv
// Fetch/execute controller for the 8-bit accumulator CPU: phase sequencing, strobe decode,
// halt latch and retired-instruction counter. RISC_SEQ_STEP_EN adds single-step gating in phase 0.
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
`ifdef RISC_SEQ_STEP_EN
  input  logic             step_req,
`endif
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic [PH_W-1:0]  phase,
  output logic [CNT_W-1:0] instr_count
`ifdef RISC_SEQ_STEP_EN
  ,
  output logic             waiting
`endif
);

  phase_e           phase_q;
  opcode_e          op;
  logic             halted_q;
  logic             hlt_now;
  logic             halt_c;
  logic             step_hold;
  logic             hold;
  logic [CNT_W-1:0] count_q;
  strobes_t         strb;

  assign op      = opcode_e'(opcode);
  assign hlt_now = (phase_q == PH_OP_ADDR) && (op == OP_HLT);
  assign halt_c  = halted_q | hlt_now;

`ifdef RISC_SEQ_STEP_EN
  // Park at the top of an instruction until a step request arrives.
  assign step_hold = (phase_q == PH_INST_ADDR) && !step_req;
  assign waiting   = step_hold;
`else
  assign step_hold = 1'b0;
`endif

  assign hold = halt_c | step_hold;

  risc_phase_counter u_phase (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .hold   (hold),
    .phase  (phase_q)
  );

  // Once HLT is decoded, stay halted even if the opcode input later changes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      halted_q <= 1'b0;
    end else if (hlt_now) begin
      halted_q <= 1'b1;
    end
  end

  // Retire on STORE -> INST_ADDR; saturate at all-ones.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else if ((phase_q == PH_STORE) && !hold && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    strb = '0;
    case (phase_q)
      PH_INST_ADDR: begin
        strb.sel = 1'b1;
      end
      PH_INST_FETCH: begin
        strb.sel = 1'b1;
        strb.rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        strb.sel   = 1'b1;
        strb.rd    = 1'b1;
        strb.ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        strb.inc_pc = 1'b1;
        strb.halt   = halt_c;
      end
      PH_OP_FETCH: begin
        strb.rd = is_aluop(op);
      end
      PH_ALU_OP: begin
        strb.rd     = is_aluop(op);
        strb.inc_pc = (op == OP_SKZ) && zero;
        strb.ld_pc  = (op == OP_JMP);
        strb.data_e = (op == OP_STO);
      end
      PH_STORE: begin
        strb.rd     = is_aluop(op);
        strb.ld_ac  = is_aluop(op);
        strb.ld_pc  = (op == OP_JMP);
        strb.data_e = (op == OP_STO);
        strb.wr     = (op == OP_STO);
      end
      default: strb = '0;
    endcase
  end

  assign sel         = strb.sel;
  assign rd          = strb.rd;
  assign ld_ir       = strb.ld_ir;
  assign inc_pc      = strb.inc_pc;
  assign halt        = strb.halt;
  assign ld_pc       = strb.ld_pc;
  assign data_e      = strb.data_e;
  assign ld_ac       = strb.ld_ac;
  assign wr          = strb.wr;
  assign phase       = PH_W'(phase_q);
  assign instr_count = count_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Self-checking bench for risc_sequencer: per-cycle behavioural model plus directed instruction runs.
module tb_risc_sequencer;
  import risc_pkg::*;

  localparam int unsigned CNT_W = 5;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic zero = 1'b0;
  logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
  logic [CNT_W-1:0] instr_count;
`ifdef RISC_SEQ_STEP_EN
  logic step_req = 1'b1;
  logic waiting;
`endif

  int checks = 0;
  int errors = 0;

  risc_sequencer #(.CNT_W(CNT_W)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .opcode      (opcode),
    .zero        (zero),
`ifdef RISC_SEQ_STEP_EN
    .step_req    (step_req),
`endif
    .sel         (sel),
    .rd          (rd),
    .ld_ir       (ld_ir),
    .inc_pc      (inc_pc),
    .halt        (halt),
    .ld_pc       (ld_pc),
    .data_e      (data_e),
    .ld_ac       (ld_ac),
    .wr          (wr),
    .phase       (phase),
    .instr_count (instr_count)
`ifdef RISC_SEQ_STEP_EN
    ,
    .waiting     (waiting)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the 8-step cycle, halt latch, retired count.
  int m_phase;
  int m_cnt;
  bit m_halted;
  bit m_wait;

`ifdef RISC_SEQ_STEP_EN
  assign m_wait = (m_phase == 0) && !step_req;
`else
  assign m_wait = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_cnt    <= 0;
      m_halted <= 1'b0;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_phase == 4 && opcode == 3'd0) begin
      m_halted <= 1'b1;
    end else if (!m_wait) begin
      m_phase <= (m_phase + 1) % 8;
      if (m_phase == 7 && m_cnt < MAXC) m_cnt <= m_cnt + 1;
    end
  end

  // Expected strobes {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} from the phase table.
  function automatic logic [8:0] exp_strobes(input int ph, input logic [2:0] op, input logic z,
                                             input bit halted);
    bit alu;
    logic [8:0] v;
    alu  = (op >= 3'd2) && (op <= 3'd5);
    v[8] = (ph <= 3);
    v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    v[6] = (ph == 2) || (ph == 3);
    v[5] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    v[4] = (ph == 4) && (halted || op == 3'd0);
    v[3] = (ph >= 6) && (op == 3'd7);
    v[2] = (ph >= 6) && (op == 3'd6);
    v[1] = (ph == 7) && alu;
    v[0] = (ph == 7) && (op == 3'd6);
    return v;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("strobes", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr},
          {23'd0, exp_strobes(m_phase, opcode, zero, m_halted)});
      chk("phase", 32'(phase), 32'(m_phase));
      chk("count", 32'(instr_count), 32'(m_cnt));
`ifdef RISC_SEQ_STEP_EN
      chk("waiting", 32'(waiting), 32'(m_wait));
`endif
    end
  end

  logic [8:0] cap [8];

  function automatic logic [7:0] col(input int b);
    logic [7:0] m;
    for (int k = 0; k < 8; k++) m[k] = cap[k][b];
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From phase 0: capture strobes for each of the 8 phases, return at the next phase 0.
  task automatic run_instr(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      #2;
      cap[k] = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
      @(negedge clk);
    end
    #2;
    chk("after_instr_phase", 32'(phase), 0);
    chk("after_instr_count", 32'(instr_count), 1);
  endtask

  initial begin
    // HLT at address 0
    opcode = 3'd0;
    do_reset();
    #2;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_strobes", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}, 32'h100);
    chk("rst_count", 32'(instr_count), 0);
    repeat (3) @(negedge clk);
    #2;
    chk("hlt_3edges_halt", 32'(halt), 0);
    chk("hlt_3edges_phase", 32'(phase), 3);
    @(negedge clk);
    #2;
    chk("hlt_4edges_halt", 32'(halt), 1);
    chk("hlt_4edges_phase", 32'(phase), 4);
    repeat (10) @(negedge clk);
    #2;
    chk("hlt_hold_phase", 32'(phase), 4);
    chk("hlt_hold_count", 32'(instr_count), 0);
    chk("hlt_hold_incpc", 32'(inc_pc), 1);
    @(negedge clk);
    opcode = 3'd2;
    repeat (3) @(negedge clk);
    #2;
    chk("hlt_sticky_halt", 32'(halt), 1);
    chk("hlt_sticky_phase", 32'(phase), 4);

    run_instr(3'd7, 1'b0);
    chk("jmp_ld_pc", 32'(col(3)), 32'h0C0);
    chk("jmp_rd", 32'(col(7)), 32'h00E);

    run_instr(3'd1, 1'b1);
    chk("skz_z1_inc_pc", 32'(col(5)), 32'h050);
    run_instr(3'd1, 1'b0);
    chk("skz_z0_inc_pc", 32'(col(5)), 32'h010);

    run_instr(3'd6, 1'b0);
    chk("sto_data_e", 32'(col(2)), 32'h0C0);
    chk("sto_wr", 32'(col(0)), 32'h080);
    chk("sto_ld_ac", 32'(col(1)), 32'h000);

    run_instr(3'd2, 1'b0);
    chk("add_ld_ac", 32'(col(1)), 32'h080);
    chk("add_rd", 32'(col(7)), 32'h0EE);

    // Saturation, then async reset mid-instruction
    opcode = 3'd2;
    do_reset();
    repeat (8 * (MAXC + 5)) @(negedge clk);
    #2;
    chk("sat_count", 32'(instr_count), 32'(MAXC));
    chk("sat_phase", 32'(phase), 0);
    repeat (5) @(negedge clk);
    #2;
    chk("pre_rst_phase", 32'(phase), 5);
    rst = 1'b1;
    #1;
    chk("async_rst_phase", 32'(phase), 0);
    chk("async_rst_count", 32'(instr_count), 0);
    chk("async_rst_sel", 32'(sel), 1);
    @(negedge clk);
    rst = 1'b0;

`ifdef RISC_SEQ_STEP_EN
    step_req = 1'b0;
    opcode   = 3'd2;
    do_reset();
    repeat (5) @(negedge clk);
    #2;
    chk("step_idle_phase", 32'(phase), 0);
    chk("step_idle_waiting", 32'(waiting), 1);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    #2;
    chk("step_started_phase", 32'(phase), 1);
    repeat (7) @(negedge clk);
    #2;
    chk("step_done_phase", 32'(phase), 0);
    chk("step_done_count", 32'(instr_count), 1);
    repeat (4) @(negedge clk);
    #2;
    chk("step_park_phase", 32'(phase), 0);
    chk("step_park_count", 32'(instr_count), 1);
    chk("step_park_waiting", 32'(waiting), 1);
    step_req = 1'b1;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
